multicycle_memory: RTL and testbench

Pipelined, fixed-latency main-memory responder: the memory end of the cache-fill interface. It accepts one word read or write per cycle on a 16-bit byte-addressed bus. For each accepted read it returns the 16-bit word exactly LATENCY cycles later, flagged by a one-cycle data-valid pulse. It sits below the instruction and data cache fill engines and serves their back-to-back word requests during a block fill.

---
 rtl/multicycle_memory.sv | 66 ++++++
 tb/tb_multicycle_memory.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_memory.sv
// Fixed-latency word memory responder for cache fills: one read or write per cycle,
// read data returned LATENCY cycles after acceptance through an unconditional shift pipeline.
module multicycle_memory #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [15:0]              mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]         idx;
  logic                     rd_acc;
  logic                     wr_acc;
  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][15:0] dat_q, dat_d;
  logic                     unused_addr_bits;

  // Byte address to word index; high index bits drop off so accesses wrap.
  assign idx              = addr[IDX_W:1];
  assign unused_addr_bits = ^addr;

  assign rd_acc = enable & ~wr;
  assign wr_acc = enable & wr & rst_n;

  // Array contents survive reset, so this flop set has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[idx] <= data_in;
    end
  end

  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? mem_q[idx] : 16'h0000;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Return pipeline: stage 0 captures the read word, last stage drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = data_valid ? dat_q[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_multicycle_memory.sv
// Directed bench for multicycle_memory: LATENCY=4/DEPTH=1024 instance for the main
// scenarios and a LATENCY=1 instance for the alternating read/write sweep.
module tb_multicycle_memory;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out,  data_out1;
  logic        data_valid, data_valid1;

  int n_tests;
  int n_fail;

  logic [15:0] mdl [int];

  multicycle_memory #(.LATENCY(4), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid)
  );

  multicycle_memory #(.LATENCY(1), .DEPTH_WORDS(32768)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out1), .data_valid(data_valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request, check the LATENCY=4 outputs mid-cycle, advance.
  task automatic cyc(input string tag, input logic en, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic ev, input logic [15:0] ed);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(negedge clk);
    chk({tag, "_v"}, {31'd0, data_valid}, {31'd0, ev});
    chk({tag, "_d"}, {16'd0, data_out}, {16'd0, ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0000;
    data_in = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_v",  {31'd0, data_valid},  32'd0);
    chk("rst_d",  {16'd0, data_out},    32'd0);
    chk("rst_v1", {31'd0, data_valid1}, 32'd0);
    chk("rst_d1", {16'd0, data_out1},   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read: data returns in cycle 5 only.
    cyc("t1_c0", 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    cyc("t1_c1", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    for (int c = 2; c <= 7; c++)
      cyc($sformatf("t1_c%0d", c), 1'b0, 1'b0, 16'h0000, 16'h0000,
          (c == 5), (c == 5) ? 16'hBEEF : 16'h0000);

    // Block fill: preload then eight back-to-back reads.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("t2_w%0d", i), 1'b1, 1'b1, 16'h0100 + 16'(2*i), 16'h1000 + 16'(i),
          1'b0, 16'h0000);
    for (int c = 0; c <= 12; c++)
      cyc($sformatf("t2_c%0d", c), (c < 8), 1'b0, 16'h0100 + 16'(2*c), 16'h0000,
          (c >= 4 && c < 12), (c >= 4 && c < 12) ? 16'h1000 + 16'(c - 4) : 16'h0000);

    // Odd address plus index wrap at 1024 words.
    cyc("t3_w",  1'b1, 1'b1, 16'h0801, 16'h1234, 1'b0, 16'h0000);
    cyc("t3_c0", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    for (int c = 1; c <= 5; c++)
      cyc($sformatf("t3_c%0d", c), 1'b0, 1'b0, 16'h0000, 16'h0000,
          (c == 4), (c == 4) ? 16'h1234 : 16'h0000);

    // In-flight isolation.
    cyc("t4_pre", 1'b1, 1'b1, 16'h0020, 16'h0001, 1'b0, 16'h0000);
    cyc("t4_c0",  1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    cyc("t4_c1",  1'b1, 1'b1, 16'h0020, 16'h0002, 1'b0, 16'h0000);
    cyc("t4_c2",  1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    cyc("t4_c3",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    cyc("t4_c4",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001);
    cyc("t4_c5",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    cyc("t4_c6",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002);
    cyc("t4_c7",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Reset mid-operation; a write presented during reset must be ignored.
    for (int c = 0; c < 3; c++)
      cyc($sformatf("t5_c%0d", c), 1'b1, 1'b0, 16'h0100 + 16'(2*c), 16'h0000,
          1'b0, 16'h0000);
    rst_n = 1'b0;
    for (int c = 3; c < 6; c++)
      cyc($sformatf("t5_c%0d", c), 1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b0, 16'h0000);
    rst_n = 1'b1;
    for (int c = 6; c < 10; c++)
      cyc($sformatf("t5_c%0d", c), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    cyc("t5_r0", 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0000);
    cyc("t5_r1", 1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0, 16'h0000);
    cyc("t5_r2", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    cyc("t5_r3", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    cyc("t5_r4", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1000);
    cyc("t5_r5", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1001);
    cyc("t5_r6", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    for (int c = 0; c < 3; c++)
      cyc($sformatf("t5_d%0d", c), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // LATENCY=1 sweep: alternating write/read, checked against a model.
    begin
      logic        exp_v, nxt_v;
      logic [15:0] exp_d, nxt_d, a, d;
      logic        en, w;
      exp_v = 1'b0;
      exp_d = 16'h0000;
      for (int c = 0; c <= 16; c++) begin
        en = (c < 16);
        w  = (c % 2 == 0);
        if (w)              a = 16'h0200 + 16'(c);
        else if (c % 4 == 1) a = 16'h0200 + 16'(c - 1);
        else                 a = 16'h0201;
        d = 16'hA000 ^ (16'(c) * 16'h0123);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        chk($sformatf("t6_c%0d_v", c), {31'd0, data_valid1}, {31'd0, exp_v});
        chk($sformatf("t6_c%0d_d", c), {16'd0, data_out1},   {16'd0, exp_d});
        nxt_v = en && !w;
        nxt_d = 16'h0000;
        if (nxt_v) nxt_d = mdl[int'(a[15:1])];
        if (en && w) mdl[int'(a[15:1])] = d;
        exp_v = nxt_v;
        exp_d = nxt_d;
        @(posedge clk);
        #1;
      end
      enable = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
